seven_seg_mux: RTL
==================

# seven_seg_mux

Parametrised N-digit time-multiplexed seven-segment display controller that replaces the fixed 4-digit scanner/decoder pair on the Lab 12 board top. It owns its own refresh prescaler, decodes 4-bit hex digits per position, and adds per-digit decimal points, leading-zero blanking and a minus sign for signed results such as A−B. Display data is double-buffered: a `load` strobe captures new data into a shadow register, and the shadow is committed only at a frame boundary, so a scan never mixes old and new digits.

## Interface

- `DIGITS`, 4: number of display positions, 1..8.
- `DIV_BITS`, 17: prescaler width; digit dwell is 2**DIV_BITS clocks. Minimum is 1.
- `ACTIVE_LOW`, 1: 1 means `an`, `seg` and `dp` are active-low (board default); 0 means active-high.
- `clk` in 1: 100 MHz board clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `value` in 4*DIGITS: hex digits; `value[3:0]` is digit 0 (rightmost).
- `dp_in` in DIGITS: per-digit decimal point request; bit i maps to digit i.
- `neg` in 1: show a minus sign (honoured only with blanking; see Operation).
- `blank_zero` in 1: enable leading-zero suppression.
- `load` in 1: single-cycle strobe; captures `value`, `dp_in`, `neg` and `blank_zero` into the shadow register.
- `an` out DIGITS: digit enables, one-hot when scanning.
- `seg` out 7: segments `{g,f,e,d,c,b,a}`.
- `dp` out 1: decimal point of the current digit.
- `pending` out 1: the shadow holds data not yet committed.
- `frame_done` out 1: one-cycle pulse when the scan wraps from digit DIGITS-1 to digit 0.

## Operation

- **Prescaler.** A DIV_BITS-bit free-running counter. `tick` is asserted when the counter is all-ones, and the counter then wraps to 0.
- **Digit index.** The index counts 0..DIGITS-1 and advances on `tick`. It wraps from DIGITS-1 to 0. On that wrap cycle the boundary event fires and `frame_done` pulses for one cycle. With DIGITS=1, every tick is a boundary.
- **Shadow load.** On `load`=1:
  - shadow ← inputs and `pending` ← 1.
  - A load while `pending`=1 overwrites the shadow; the last load wins.
- **Commit.** On the boundary, if `pending`=1: display register ← shadow and `pending` ← 0.
- **Load coincident with boundary.** The commit uses the shadow contents from before that edge. The new load lands in the shadow and `pending` stays 1 until the next boundary.
- **Hex decode.** Active-high patterns, a..g order g..a:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111
  - 4=1100110, 5=1101101, 6=1111101, 7=0000111
  - 8=1111111, 9=1101111, A=1110111, b=1111100
  - C=0111001, d=1011110, E=1111001, F=1110001
- **Blanking** (display-register `blank_zero`=1):
  - Every digit above the most significant nonzero digit is blank (all segments off).
  - Digit 0 is never blanked; a value of 0 shows "0".
- **Minus sign** (display-register `neg`=1 and `blank_zero`=1):
  - The first blanked position above the most significant nonzero digit shows '-' (g only).
  - If no position is blanked, `neg` is ignored.
  - `neg` is ignored when `blank_zero`=0.
- **Decimal point.** `dp` equals the display-register `dp_in[index]`. It is forced off on blanked digits but allowed on the '-' digit.
- **Output polarity.** With ACTIVE_LOW=1, `an`, `seg` and `dp` are the bitwise inverse of the active-high values.

## Timing

- **Reset values** (async assert, while `reset_n`=0):
  - Prescaler, index, shadow, display register, `pending` and `frame_done` are 0.
  - `an`, `seg` and `dp` are all inactive: 4'b1111, 7'b1111111 and 1 for ACTIVE_LOW=1 with DIGITS=4.
- **Release.** Deassertion is synchronous to the board's reset synchroniser, external to this block.
- **Registered outputs.** `an`, `seg` and `dp` are registered and reflect the index and display register with 1-clock latency. The first clock after release drives digit 0 with the display register (0 → "0").
- **frame_done.** Registered; high on the clock edge after the wrapping tick, coincident with `an` selecting digit 0. Period is DIGITS*2**DIV_BITS clocks.
- **Commit latency.** A commit is visible on `an`/`seg` for digit 0 on the same edge as `frame_done`.
- **Load latency.** `pending` rises the edge after `load` and falls on the commit edge.
- **Reset mid-operation.** Reset aborts scan and pending data immediately; no partial commit survives.

## Test plan

All scenarios use DIGITS=4, DIV_BITS=2, ACTIVE_LOW=1 (4-clock dwell, 16-clock frame).

1. **Reset.** Hold `reset_n`=0 → `an`=1111, `seg`=1111111, `dp`=1, `pending`=0, `frame_done`=0. Release → next edge `an`=1110, `seg`=1000000 ("0"); `frame_done` pulses every 16 clocks thereafter.
2. **Hex scan.** Load `value`=16'h12AF, `blank_zero`=0 → after the next boundary:
   - digit0 F = 0001110
   - digit1 A = 0001000
   - digit2 2 = 0100100
   - digit3 1 = 1111001
   - `an` sequence 1110, 1101, 1011, 0111 with 4 clocks each.
3. **Blank and minus.** Load `value`=16'h0005, `blank_zero`=1, `neg`=1, `dp_in`=4'b0110 → outputs:
   - digit0 5 = 0010010, `dp`=1
   - digit1 '-' = 0111111, `dp`=0
   - digit2 blank 1111111, `dp`=1 (forced off)
   - digit3 blank.
   - Then load 16'h8005 with `neg`=1 → no '-' shown, digit3 8 = 0000000.
4. **Tear-free update.** Mid-frame, load 16'h1111, then 16'h2222 three clocks later → old data holds until the boundary, then every digit shows 2 (0100100); 1 is never displayed.
5. **Load on boundary.** Assert `load` (16'h3333) exactly on the wrap-tick cycle while the shadow holds 16'h4444 pending → 4444 is committed, `pending` stays 1, and 3333 is committed at the following boundary.
6. **Mid-frame reset.** Assert `reset_n`=0 asynchronously (between edges) during digit 2 with `pending`=1 → outputs go inactive immediately and `pending`=0. After release the display shows "0" and the pending data is discarded.

Source files
------------

// File: rtl/seven_seg_mux_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seven_seg_mux_if                                                     |
// | Data/load bus and display outputs of the seven-segment controller.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface seven_seg_mux_if #(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] value;
    logic [DIGITS-1:0]   dp_in;
    logic                neg;
    logic                blank_zero;
    logic                load;
    logic [DIGITS-1:0]   an;
    logic [6:0]          seg;
    logic                dp;
    logic                pending;
    logic                frame_done;

    // Producer of display data (board top / testbench)
    modport master (
        output value, dp_in, neg, blank_zero, load,
        input  an, seg, dp, pending, frame_done
    );

    // The display controller itself
    modport slave (
        input  value, dp_in, neg, blank_zero, load,
        output an, seg, dp, pending, frame_done
    );
endinterface
`default_nettype wire

// File: rtl/seven_seg_mux.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seven_seg_mux                                                        |
// | N-digit multiplexed seven-segment controller with prescaler, hex     |
// | decode, leading-zero blanking, minus sign and frame-synchronous      |
// | double-buffered updates.                                             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module seven_seg_mux #(
    parameter int DIGITS     = 4,
    parameter int DIV_BITS   = 17,
    parameter int ACTIVE_LOW = 1
) (
    input  wire logic        clk,
    input  wire logic        reset_n,
    seven_seg_mux_if.slave   bus
);
    localparam int                 c_IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST  = c_IDX_W'(DIGITS - 1);
    localparam logic               c_INV   = (ACTIVE_LOW != 0);

    logic [DIV_BITS-1:0] r_presc;
    logic [c_IDX_W-1:0]  r_idx;
    logic                w_tick;
    logic                w_wrap;

    // Shadow (written by load) and display (written at frame boundary)
    logic [4*DIGITS-1:0] r_sh_value,  r_disp_value;
    logic [DIGITS-1:0]   r_sh_dp,     r_disp_dp;
    logic                r_sh_neg,    r_disp_neg;
    logic                r_sh_blank,  r_disp_blank;
    logic                r_pending;
    logic                r_wrap_q;
    logic                r_frame_done;

    logic [DIGITS-1:0]   r_an;
    logic [6:0]          r_seg;
    logic                r_dp;

    logic [c_IDX_W-1:0]  w_msnz;
    logic [3:0]          w_digit;
    logic                w_dp_req;
    logic                w_blanked;
    logic                w_minus;
    logic [6:0]          w_hex;
    logic [6:0]          w_seg_hi;
    logic                w_dp_hi;
    logic [DIGITS-1:0]   w_an_hi;

    assign w_tick = &r_presc;
    assign w_wrap = w_tick && (r_idx == c_LAST);

    // Free-running refresh prescaler
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_presc <= '0;
        else          r_presc <= r_presc + 1'b1;
    end

    // Digit index advances once per dwell and wraps after the last digit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)        r_idx <= '0;
        else if (w_tick) begin
            if (r_idx == c_LAST) r_idx <= '0;
            else                 r_idx <= r_idx + 1'b1;
        end
    end

    // Shadow capture; a load on the boundary cycle keeps pending set
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sh_value <= '0;
            r_sh_dp    <= '0;
            r_sh_neg   <= 1'b0;
            r_sh_blank <= 1'b0;
            r_pending  <= 1'b0;
        end else if (bus.load) begin
            r_sh_value <= bus.value;
            r_sh_dp    <= bus.dp_in;
            r_sh_neg   <= bus.neg;
            r_sh_blank <= bus.blank_zero;
            r_pending  <= 1'b1;
        end else if (w_wrap) begin
            r_pending  <= 1'b0;
        end
    end

    // Commit shadow at the frame boundary (pre-edge shadow contents)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_disp_value <= '0;
            r_disp_dp    <= '0;
            r_disp_neg   <= 1'b0;
            r_disp_blank <= 1'b0;
        end else if (w_wrap && r_pending) begin
            r_disp_value <= r_sh_value;
            r_disp_dp    <= r_sh_dp;
            r_disp_neg   <= r_sh_neg;
            r_disp_blank <= r_sh_blank;
        end
    end

    // Select current digit, find the most significant nonzero digit
    always_comb begin
        w_msnz   = '0;
        w_digit  = 4'h0;
        w_dp_req = 1'b0;
        w_an_hi  = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_disp_value[4*i +: 4] != 4'h0) w_msnz = c_IDX_W'(i);
            if (r_idx == c_IDX_W'(i)) begin
                w_digit    = r_disp_value[4*i +: 4];
                w_dp_req   = r_disp_dp[i];
                w_an_hi[i] = 1'b1;
            end
        end
        w_blanked = r_disp_blank && (r_idx > w_msnz);
        w_minus   = r_disp_blank && r_disp_neg &&
                    ({1'b0, r_idx} == ({1'b0, w_msnz} + 1'b1));
    end

    // Hex to active-high segments {g,f,e,d,c,b,a}
    always_comb begin
        w_hex = 7'b0000000;
        case (w_digit)
            4'h0: w_hex = 7'b0111111;
            4'h1: w_hex = 7'b0000110;
            4'h2: w_hex = 7'b1011011;
            4'h3: w_hex = 7'b1001111;
            4'h4: w_hex = 7'b1100110;
            4'h5: w_hex = 7'b1101101;
            4'h6: w_hex = 7'b1111101;
            4'h7: w_hex = 7'b0000111;
            4'h8: w_hex = 7'b1111111;
            4'h9: w_hex = 7'b1101111;
            4'hA: w_hex = 7'b1110111;
            4'hB: w_hex = 7'b1111100;
            4'hC: w_hex = 7'b0111001;
            4'hD: w_hex = 7'b1011110;
            4'hE: w_hex = 7'b1111001;
            4'hF: w_hex = 7'b1110001;
            default: w_hex = 7'b0000000;
        endcase
    end

    // Minus overrides blanking; dp survives only on shown digits and '-'
    always_comb begin
        w_seg_hi = w_hex;
        w_dp_hi  = w_dp_req;
        if (w_minus) begin
            w_seg_hi = 7'b1000000;
        end else if (w_blanked) begin
            w_seg_hi = 7'b0000000;
            w_dp_hi  = 1'b0;
        end
    end

    // Registered outputs, polarity applied; frame_done aligned with digit 0
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_an         <= {DIGITS{c_INV}};
            r_seg        <= {7{c_INV}};
            r_dp         <= c_INV;
            r_wrap_q     <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_an         <= w_an_hi ^ {DIGITS{c_INV}};
            r_seg        <= w_seg_hi ^ {7{c_INV}};
            r_dp         <= w_dp_hi ^ c_INV;
            r_wrap_q     <= w_wrap;
            r_frame_done <= r_wrap_q;
        end
    end

    assign bus.an         = r_an;
    assign bus.seg        = r_seg;
    assign bus.dp         = r_dp;
    assign bus.pending    = r_pending;
    assign bus.frame_done = r_frame_done;
endmodule
`default_nettype wire
